// File: rtl/wb8_ram32_pkg.sv
// Shared definitions for the 8-bit Wishbone responder in front of the 32-bit RAM:
// lane geometry, FSM states and byte-lane helpers.
package wb8_ram32_pkg;

    localparam int WB_LANE_BITS = 2;
    localparam int WB_LANES     = 1 << WB_LANE_BITS;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_e;

    function automatic logic [7:0] lane_get(
        input logic [31:0] w,
        input logic [1:0]  lane
    );
        logic [7:0] b;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] lane_put(
        input logic [31:0] w,
        input logic [1:0]  lane,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = w;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/wb8_ram32_ram.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
// Reads have one cycle of latency; contents are never reset.
module ram32_be #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [3:0]               be,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wb8_ram32.sv
// Wishbone classic 8-bit responder over a 32-bit RAM with a one-word
// read buffer so byte reads within the same word complete in one cycle.
module wb8_ram32
    import wb8_ram32_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [7:0]  DAT_I,
    output logic [7:0]  DAT_O,
    output logic        ACK_O
);

    localparam int WORD_BITS = ADDR_WIDTH - WB_LANE_BITS;
    localparam int DEPTH     = 1 << WORD_BITS;

    logic [WORD_BITS-1:0] word_addr;
    logic [1:0]           lane;
    logic                 unused_adr;

    assign word_addr  = ADR_I[ADDR_WIDTH-1:WB_LANE_BITS];
    assign lane       = ADR_I[WB_LANE_BITS-1:0];
    assign unused_adr = ^ADR_I[31:ADDR_WIDTH];

    state_e               state_q, state_d;
    logic                 ack_q, ack_d;
    logic [7:0]           dat_q, dat_d;
    logic [31:0]          buf_data_q, buf_data_d;
    logic [WORD_BITS-1:0] buf_tag_q, buf_tag_d;
    logic                 buf_valid_q, buf_valid_d;
    logic [WORD_BITS-1:0] req_tag_q, req_tag_d;
    logic [1:0]           req_lane_q, req_lane_d;

    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        req;
    logic        hit;

    ram32_be #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (CLK_I),
        .addr  (word_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // !ACK_O blocks a second accept while the initiator is still dropping STB
    assign req       = CYC_I & STB_I & ~ack_q;
    assign hit       = buf_valid_q && (buf_tag_q == word_addr);
    assign ram_wdata = {4{DAT_I}};

    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        dat_d       = dat_q;
        buf_data_d  = buf_data_q;
        buf_tag_d   = buf_tag_q;
        buf_valid_d = buf_valid_q;
        req_tag_d   = req_tag_q;
        req_lane_d  = req_lane_q;
        ram_be      = 4'b0000;
        unique case (state_q)
            ST_IDLE: begin
                if (req && WE_I) begin
                    ram_be = lane_be(lane);
                    ack_d  = 1'b1;
                    if (hit) begin
                        buf_data_d = lane_put(buf_data_q, lane, DAT_I);
                    end
                end else if (req && hit) begin
                    dat_d = lane_get(buf_data_q, lane);
                    ack_d = 1'b1;
                end else if (req) begin
                    req_tag_d  = word_addr;
                    req_lane_d = lane;
                    state_d    = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                buf_data_d  = ram_rdata;
                buf_tag_d   = req_tag_q;
                buf_valid_d = 1'b1;
                if (CYC_I) begin
                    dat_d = lane_get(ram_rdata, req_lane_q);
                    ack_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= ST_IDLE;
            ack_q       <= 1'b0;
            dat_q       <= 8'h00;
            buf_data_q  <= '0;
            buf_tag_q   <= '0;
            buf_valid_q <= 1'b0;
            req_tag_q   <= '0;
            req_lane_q  <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            buf_data_q  <= buf_data_d;
            buf_tag_q   <= buf_tag_d;
            buf_valid_q <= buf_valid_d;
            req_tag_q   <= req_tag_d;
            req_lane_q  <= req_lane_d;
        end
    end

    assign ACK_O = ack_q;
    assign DAT_O = dat_q;

endmodule

// File: tb/tb_wb8_ram32.sv
// Directed bench for wb8_ram32: latency, buffer coherence, aliasing,
// abort, reset and a byte-split word/halfword initiator sequence.
module tb_wb8_ram32;

    logic        CLK_I;
    logic        RST_I;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic [31:0] ADR_I;
    logic [7:0]  DAT_I;
    logic [7:0]  DAT_O;
    logic        ACK_O;

    int tests;
    int fails;
    int nxfer;
    int ack_cnt;
    int double_ack;
    logic ack_prev;

    wb8_ram32 #(
        .ADDR_WIDTH (12)
    ) dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .CYC_I (CYC_I),
        .STB_I (STB_I),
        .WE_I  (WE_I),
        .ADR_I (ADR_I),
        .DAT_I (DAT_I),
        .DAT_O (DAT_O),
        .ACK_O (ACK_O)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    initial begin
        ack_cnt    = 0;
        double_ack = 0;
        ack_prev   = 1'b0;
    end

    always @(posedge CLK_I) begin
        if (ACK_O === 1'b1) begin
            ack_cnt <= ack_cnt + 1;
            if (ack_prev) double_ack <= double_ack + 1;
        end
        ack_prev <= (ACK_O === 1'b1);
    end

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns with the bus idle one cycle
    task automatic xfer(
        input  logic        we,
        input  logic [31:0] adr,
        input  logic [7:0]  d,
        output logic [7:0]  q,
        output int          lat
    );
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = we;
        ADR_I = adr;
        DAT_I = d;
        lat   = 0;
        q     = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK_I);
            if (ACK_O === 1'b1) begin
                lat = i;
                q   = DAT_O;
                break;
            end
        end
        CYC_I = 1'b0;
        STB_I = 1'b0;
        WE_I  = 1'b0;
        chk("ack_seen", 32'(lat != 0), 32'd1);
        if (lat != 0) nxfer++;
        @(negedge CLK_I);
        chk("ack_single", 32'(ACK_O), 32'd0);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [7:0] d);
        logic [7:0] q;
        int lat;
        xfer(1'b1, adr, d, q, lat);
        chk("wr_lat", lat, 1);
    endtask

    task automatic rd(
        input string       tag,
        input logic [31:0] adr,
        input logic [7:0]  exp_d,
        input int          exp_lat
    );
        logic [7:0] q;
        int lat;
        xfer(1'b0, adr, 8'h00, q, lat);
        chk({tag, "_data"}, 32'(q), 32'(exp_d));
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic cpu_write(
        input logic [31:0] adr,
        input int          n,
        input logic [31:0] val
    );
        logic [7:0] q;
        int lat;
        for (int i = 0; i < n; i++) begin
            xfer(1'b1, adr + 32'(i), val[8*i +: 8], q, lat);
        end
    endtask

    task automatic cpu_read(
        input  logic [31:0] adr,
        input  int          n,
        output logic [31:0] val
    );
        logic [7:0] q;
        int lat;
        val = '0;
        for (int i = 0; i < n; i++) begin
            xfer(1'b0, adr + 32'(i), 8'h00, q, lat);
            val[8*i +: 8] = q;
        end
        if (n == 2) val = {{16{val[15]}}, val[15:0]};
    endtask

    logic [7:0]  q8;
    logic [31:0] v32;
    int          lat;
    logic        seen;

    initial begin
        tests = 0;
        fails = 0;
        nxfer = 0;
        RST_I = 1'b1;
        CYC_I = 1'b0;
        STB_I = 1'b0;
        WE_I  = 1'b0;
        ADR_I = '0;
        DAT_I = '0;
        repeat (2) @(posedge CLK_I);
        @(negedge CLK_I);
        chk("rst_ack", 32'(ACK_O), 32'd0);
        chk("rst_dat", 32'(DAT_O), 32'h00);
        RST_I = 1'b0;

        // First read after reset misses; RAM content is unknown
        xfer(1'b0, 32'h000, 8'h00, q8, lat);
        chk("first_lat", lat, 2);

        wr(32'h100, 8'h78);
        wr(32'h101, 8'h56);
        wr(32'h102, 8'h34);
        wr(32'h103, 8'h12);
        rd("rd100", 32'h100, 8'h78, 2);
        rd("rd101", 32'h101, 8'h56, 1);
        rd("rd102", 32'h102, 8'h34, 1);
        rd("rd103", 32'h103, 8'h12, 1);

        // Write into the buffered word; DAT_O must hold the last read byte
        xfer(1'b1, 32'h102, 8'hAB, q8, lat);
        chk("wr_hit_lat", lat, 1);
        chk("wr_dat_hold", 32'(q8), 32'h12);
        rd("coh102", 32'h102, 8'hAB, 1);
        rd("coh100", 32'h100, 8'h78, 1);

        // 0x1004 aliases 0x0004 with 12 address bits
        wr(32'h1004, 8'h5A);
        rd("alias", 32'h0004, 8'h5A, 2);
        rd("re100", 32'h100, 8'h78, 2);
        xfer(1'b0, 32'h200, 8'h00, q8, lat);
        chk("miss200_lat", lat, 2);

        // Abort a read miss in RD_WAIT
        wr(32'h300, 8'h11);
        wr(32'h301, 8'h22);
        wr(32'h302, 8'h33);
        wr(32'h303, 8'h44);
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = 1'b0;
        ADR_I = 32'h300;
        @(negedge CLK_I);
        chk("abort_acc", 32'(ACK_O), 32'd0);
        CYC_I = 1'b0;
        STB_I = 1'b0;
        @(negedge CLK_I);
        chk("abort_noack0", 32'(ACK_O), 32'd0);
        @(negedge CLK_I);
        chk("abort_noack1", 32'(ACK_O), 32'd0);
        rd("abort301", 32'h301, 8'h22, 1);

        // STB without CYC is ignored
        seen  = 1'b0;
        STB_I = 1'b1;
        ADR_I = 32'h100;
        repeat (3) begin
            @(negedge CLK_I);
            seen = seen | (ACK_O === 1'b1);
        end
        STB_I = 1'b0;
        chk("stb_no_cyc", 32'(seen), 32'd0);

        // Byte-split word/halfword accesses as the CPU initiator issues them
        cpu_write(32'h400, 4, 32'hDEADBEEF);
        cpu_read(32'h400, 4, v32);
        chk("readw", v32, 32'hDEADBEEF);
        cpu_read(32'h402, 2, v32);
        chk("readh_hi", v32, 32'hFFFFDEAD);
        cpu_read(32'h400, 2, v32);
        chk("readh_lo", v32, 32'hFFFFBEEF);
        cpu_write(32'h404, 2, 32'h00001234);
        cpu_read(32'h404, 2, v32);
        chk("readh_pos", v32, 32'h00001234);
        cpu_write(32'h400, 4, 32'h0BADF00D);
        cpu_read(32'h400, 4, v32);
        chk("readw2", v32, 32'h0BADF00D);

        // Reset while a read miss sits in RD_WAIT
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = 1'b0;
        ADR_I = 32'h500;
        @(negedge CLK_I);
        RST_I = 1'b1;
        @(negedge CLK_I);
        chk("midrst_ack", 32'(ACK_O), 32'd0);
        chk("midrst_dat", 32'(DAT_O), 32'h00);
        RST_I = 1'b0;
        CYC_I = 1'b0;
        STB_I = 1'b0;
        @(negedge CLK_I);
        chk("midrst_noack", 32'(ACK_O), 32'd0);
        rd("post_rst", 32'h401, 8'hF0, 2);
        rd("post_rst_hit", 32'h403, 8'h0B, 1);

        @(negedge CLK_I);
        chk("ack_count", ack_cnt, nxfer);
        chk("double_ack", double_ack, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
